// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the
// sequential shift-add multiplier.
package mult_pkg;

    localparam int W = 4;

    localparam logic [1:0] CNT_LAST = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add4_comb.sv
// Combinational ripple-carry adder built from
// per-bit full-adder cells.
module add4_comb
    import mult_pkg::*;
(
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i])
                      | (c[i] & (x[i] ^ y[i]));
    end

    assign co = c[W];

endmodule

// File: rtl/shift_add_mult.sv
// 4x4 unsigned multiplier: one partial-product
// add per clock with start/busy/done handshake.
module shift_add_mult
    import mult_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);

    state_t         state;
    logic [W-1:0]   mcand;
    logic [W-1:0]   acc_hi;
    logic [W-1:0]   q;
    logic [1:0]     cnt;
    logic [W-1:0]   addend;
    logic [W-1:0]   sum;
    logic           co;

    assign addend = q[0] ? mcand : '0;

    add4_comb u_add (
        .x  (acc_hi),
        .y  (addend),
        .ci (1'b0),
        .s  (sum),
        .co (co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mcand  <= '0;
            acc_hi <= '0;
            q      <= '0;
            cnt    <= '0;
            p      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        q      <= b;
                        acc_hi <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // {co,sum,q} shifted right by one
                    acc_hi <= {co, sum[W-1:1]};
                    q      <= {sum[0], q[W-1:1]};
                    cnt    <= cnt + 2'd1;
                    if (cnt == CNT_LAST) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    p     <= {acc_hi, q};
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult.sv
// Randomized self-checking bench for
// shift_add_mult against a cycle-level model.
module tb_shift_add_mult;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] p;

    int total = 0;
    int bad   = 0;

    logic [7:0] prev_p;

    shift_add_mult dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [7:0] obs,
                         input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%h exp=%h t=%0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Called at a negedge with the DUT idle.
    task automatic idle(input int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_busy", 8'(busy), 8'h00);
            check("idle_done", 8'(done), 8'h00);
            check("idle_p", p, prev_p);
        end
    endtask

    // One full operation: accept edge E0, then edges
    // E1..E5 with done expected after E5.
    task automatic run_op(input logic [3:0] x,
                          input logic [3:0] y,
                          input bit noise,
                          input bit hold);
        logic [7:0] exp_p;
        exp_p = 8'(x) * 8'(y);
        a = x;
        b = y;
        start = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            check("run_busy", 8'(busy), 8'(i <= 3));
            check("run_done", 8'(done), 8'(i == 5));
            check("run_p", p,
                  (i == 5) ? exp_p : prev_p);
            if (noise) begin
                a = 4'($urandom);
                b = 4'($urandom);
            end
            if (i == 5)
                start = hold;
            else if (hold)
                start = 1'b1;
            else if (noise)
                start = 1'($urandom);
            else
                start = 1'b0;
        end
        prev_p = exp_p;
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        prev_p = 8'h00;

        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 8'(busy), 8'h00);
        check("rst_done", 8'(done), 8'h00);
        check("rst_p", p, 8'h00);
        rst = 1'b0;
        idle(10);

        run_op(4'h5, 4'h3, 1'b0, 1'b0);
        check("p_5x3", p, 8'h0F);
        idle(2);
        run_op(4'hF, 4'hF, 1'b0, 1'b0);
        check("p_FxF", p, 8'hE1);
        run_op(4'hD, 4'hB, 1'b0, 1'b0);
        check("p_DxB", p, 8'h8F);
        run_op(4'h0, 4'h9, 1'b0, 1'b0);
        run_op(4'h9, 4'h0, 1'b0, 1'b0);
        check("p_9x0", p, 8'h00);
        idle(1);

        // start reasserted with new operands mid-run
        a = 4'h2;
        b = 4'h3;
        run_op(4'h2, 4'h3, 1'b1, 1'b0);
        check("p_busy_start", p, 8'h06);
        idle(3);

        // start held high: one result every 6 clocks
        for (int k = 0; k < 3; k++)
            run_op(4'h7, 4'h6, k == 1, 1'b1);
        run_op(4'h7, 4'h6, 1'b1, 1'b0);
        check("p_b2b", p, 8'h2A);
        idle(2);

        // reset during the second RUN cycle
        a = 4'hF;
        b = 4'hF;
        start = 1'b1;
        @(negedge clk);
        check("mid_busy", 8'(busy), 8'h01);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 8'(busy), 8'h00);
        check("mid_rst_done", 8'(done), 8'h00);
        check("mid_rst_p", p, 8'h00);
        @(negedge clk);
        check("rst_start_busy", 8'(busy), 8'h00);
        rst = 1'b0;
        prev_p = 8'h00;
        idle(6);
        run_op(4'h4, 4'h4, 1'b0, 1'b0);
        check("p_4x4", p, 8'h10);

        for (int k = 0; k < 40; k++) begin
            run_op(4'($urandom), 4'($urandom),
                   1'($urandom), 1'b0);
            if ($urandom_range(0, 2) == 0)
                idle($urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d",
                 total, bad);
        $finish;
    end

endmodule
